bit_deserializer16: RTL and testbench

Serial-to-parallel collector that places one incoming bit per accepted transfer into a 16-bit word, one bit position per transfer, LSB first. Each bit is written through a 4-to-16 one-hot write-enable decoder. A completed (or early-terminated) word is presented on a valid/ready output port. It sits between single-bit producers (debug/serial links, bit-serial units) and 16-bit consumers in the CPU datapath.

---
 rtl/bit_deserializer16_pkg.sv | 6 +
 rtl/bit_deserializer16_dec4to16_onehot.sv | 10 +
 rtl/bit_deserializer16.sv | 53 +++++
 tb/tb_bit_deserializer16.sv | 112 +++++++++++
 4 files changed

// File: rtl/bit_deserializer16_pkg.sv
// bit_deserializer16_pkg: shared widths and state encoding for the bit deserializer
package bit_deserializer16_pkg;
  localparam int WIDTH = 16;
  localparam int IDX_W = 4;
  typedef enum logic {FILL, FULL} state_t;
endpackage

// File: rtl/bit_deserializer16_dec4to16_onehot.sv
// dec4to16_onehot: index to one-hot write enable, all zeros when disabled
module dec4to16_onehot
  import bit_deserializer16_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);
  always_comb onehot = en ? WIDTH'(1) << idx : '0;
endmodule

// File: rtl/bit_deserializer16.sv
// bit_deserializer16: collects serial bits LSB first into a 16-bit word on a valid/ready port
module bit_deserializer16
  import bit_deserializer16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  output logic [IDX_W:0]   out_count,
  input  logic             out_ready
);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, word_q, word_d, wen, staged;
  logic [IDX_W:0]   count_q, count_d;
  logic             acc, done;
  assign in_ready  = state_q == FILL || out_ready;
  assign acc       = in_valid && in_ready && !clear;
  assign out_valid = state_q == FULL;
  assign out_word  = word_q;
  assign out_count = count_q;
  dec4to16_onehot u_dec (.idx(idx_q), .en(acc), .onehot(wen));
  // staging is zeroed on every copy-out, so bits above idx are already 0 here
  always_comb begin
    staged  = (shreg_q & ~wen) | (wen & {WIDTH{in_bit}});
    done    = acc && (idx_q == IDX_W'(WIDTH - 1) || in_last);
    state_d = clear ? FILL : done ? FULL : out_ready ? FILL : state_q;
    idx_d   = (clear || done) ? '0 : acc ? idx_q + IDX_W'(1) : idx_q;
    shreg_d = (clear || done) ? '0 : staged;
    word_d  = clear ? '0 : done ? staged : word_q;
    count_d = clear ? '0 : done ? {1'b0, idx_q} + (IDX_W + 1)'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_bit_deserializer16.sv
// tb_bit_deserializer16: scoreboard bench with a bit-list reference model
module tb_bit_deserializer16;
  logic        clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_bit = 0, in_last = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [15:0] out_word;
  logic [4:0]  out_count;
  bit          bits[$];
  logic [20:0] sb[$];
  bit          holding = 0, zero_exp = 0, armed = 0;
  bit          chk = 0, exp_in_ready = 0, exp_out_valid = 0, exp_zero = 0;
  int          checks = 0, errors = 0;

  bit_deserializer16 dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_word(out_word),
    .out_count(out_count), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs and advance the model to the state after the coming edge
  task automatic cyc(input bit v, input bit b, input bit l, input bit ordy, input bit clr, input bit rn = 1);
    logic [15:0] w;
    @(posedge clk); #1;
    in_valid = v; in_bit = b; in_last = l; out_ready = ordy; clear = clr; rst_n = rn;
    chk = armed;
    exp_in_ready = !holding || ordy;
    exp_out_valid = holding;
    exp_zero = zero_exp;
    if (!rn || clr) begin
      bits.delete(); holding = 0; zero_exp = 1;
      if (!rn) armed = 1;
    end else begin
      if (holding && ordy) holding = 0;
      if (v && exp_in_ready) begin
        bits.push_back(b);
        if (bits.size() == 16 || l) begin
          w = 0;
          foreach (bits[i]) w[i] = bits[i];
          sb.push_back({5'(bits.size()), w});
          bits.delete(); holding = 1; zero_exp = 0;
        end
      end
    end
  endtask

  task automatic send(input logic [15:0] w, input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(1, w[i], i == n - 1 && n < 16, ordy, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (chk) begin
    check("in_ready", 32'(in_ready), 32'(exp_in_ready));
    check("out_valid", 32'(out_valid), 32'(exp_out_valid));
    if (exp_zero) check("zero_after_clear", {11'd0, out_count, out_word}, 32'd0);
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_word", {11'd0, out_count, out_word}, 32'hFFFF_FFFF);
      else begin
        check("word", 32'(out_word), 32'(sb[0][15:0]));
        check("count", 32'(out_count), 32'(sb[0][20:16]));
        if (out_ready || clear || !rst_n) void'(sb.pop_front());
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    send(16'hA5C3, 16, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    send(16'hFFFF, 16, 1);
    cyc(0, 0, 0, 1, 0);
    send(16'h001D, 5, 1);
    cyc(0, 0, 0, 1, 0);
    send(16'h1234, 16, 0);
    for (int i = 0; i < 4; i++) cyc(1, i[0], 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    send(16'h0000, 15, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    send(16'h007F, 16, 1);
    cyc(0, 0, 0, 1, 0);
    send(16'h0055, 7, 1);
    cyc(1, 1, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    send(16'hFFFF, 16, 1);
    cyc(0, 0, 0, 1, 0);
    send(16'h01FF, 9, 1);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    send(16'hBEEF, 16, 1);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2, $urandom_range(0, 199) != 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    chk = 0;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
